// File: rtl/rst_release_seq_if.sv
// rtl/rst_release_seq_if.sv - sequenced-reset bundle between rst_release_seq and its consumer
//
// Signals:
//   sw_rst_req_i  consumer -> sequencer   synchronous restart request
//   rst_no        sequencer -> consumer   sequenced active-low sub-resets
//   seq_done_o    sequencer -> consumer   all sub-resets released
//   busy_o        sequencer -> consumer   sequence in progress
// Modports: master = sequencer side, slave = consumer side.

interface rst_release_seq_if #(
    parameter int NumOutputs = 4
);
    logic                  sw_rst_req_i;
    logic [NumOutputs-1:0] rst_no;
    logic                  seq_done_o;
    logic                  busy_o;

    modport master (
        input  sw_rst_req_i,
        output rst_no,
        output seq_done_o,
        output busy_o
    );

    modport slave (
        output sw_rst_req_i,
        input  rst_no,
        input  seq_done_o,
        input  busy_o
    );
endinterface

// File: rtl/rst_release_seq.sv
// rtl/rst_release_seq.sv - reset-release sequencer with staggered sub-reset release
//
// Purpose:
//   Asserts all sub-resets asynchronously with rst_ni, synchronizes the
//   deassertion of rst_ni, then releases NumOutputs active-low sub-resets one
//   at a time: the first HoldCycles cycles after the synchronized release, the
//   rest GapCycles apart. A synchronous software request restarts the sequence.
//
// Ports:
//   clk_i             clock
//   rst_ni            raw asynchronous active-low reset
//   bus.sw_rst_req_i  restart request, sampled on the rising edge of clk_i
//   bus.rst_no        sequenced sub-resets (registered, active-low)
//   bus.seq_done_o    high once every sub-reset has been released
//   bus.busy_o        high while the sequence is in HOLD or RELEASE

module rst_release_seq #(
    parameter int SyncStages = 2,
    parameter int HoldCycles = 4,
    parameter int GapCycles  = 8,
    parameter int NumOutputs = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rst_release_seq_if.master   bus
);

    localparam int MaxCnt = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);
    localparam int IdxW   = $clog2(NumOutputs + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumOutputs - 1);
    localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
    localparam logic [NumOutputs-1:0] OneHot0 = NumOutputs'(1);

    if (SyncStages < 2) begin : g_chk_sync
        $fatal(1, "rst_release_seq: SyncStages must be >= 2");
    end
    if (HoldCycles < 1) begin : g_chk_hold
        $fatal(1, "rst_release_seq: HoldCycles must be >= 1");
    end
    if (GapCycles < 1) begin : g_chk_gap
        $fatal(1, "rst_release_seq: GapCycles must be >= 1");
    end
    if (NumOutputs < 1) begin : g_chk_num
        $fatal(1, "rst_release_seq: NumOutputs must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [SyncStages-1:0] sync_q;
    logic                  rst_sync;

    state_t                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       idx_q;
    logic [NumOutputs-1:0] rst_q;
    logic                  done_q;
    logic                  busy_q;

    // Assertion is immediate through the async clear; deassertion ripples
    // through SyncStages flops so downstream logic sees a clean edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SyncStages-1];

    // Nothing advances, and sw_rst_req_i is ignored, until rst_sync is high.
    // A restart request wins over any release due on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else if (rst_sync) begin
            if (bus.sw_rst_req_i) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
                idx_q   <= '0;
                rst_q   <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (cnt_q == HoldLast) begin
                            rst_q <= rst_q | OneHot0;
                            cnt_q <= '0;
                            idx_q <= IdxOne;
                            if (NumOutputs == 1) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_RELEASE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    ST_RELEASE: begin
                        if (cnt_q == GapLast) begin
                            rst_q <= rst_q | (OneHot0 << idx_q);
                            cnt_q <= '0;
                            // idx ends at NumOutputs, which its width can hold.
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == IdxLast) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    ST_DONE: begin
                        // Terminal: outputs held, no counting.
                    end

                    default: begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        rst_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rst_no     = rst_q;
    assign bus.seq_done_o = done_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// tb/tb_rst_release_seq.sv - scoreboard bench for rst_release_seq

module tb_rst_release_seq;

    localparam int SS_A = 2;
    localparam int HC_A = 4;
    localparam int GC_A = 8;
    localparam int N_A  = 4;
    localparam int SS_B = 3;
    localparam int HC_B = 1;

    typedef struct {
        int         e;
        logic [3:0] val;
        logic       done;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    bit   mon_en;
    logic [3:0] prev_a;
    logic [3:0] prev_b;
    exp_t q_a[$];
    exp_t q_b[$];

    rst_release_seq_if #(.NumOutputs(N_A)) bus_a ();
    rst_release_seq_if #(.NumOutputs(1))   bus_b ();

    rst_release_seq #(
        .SyncStages(SS_A),
        .HoldCycles(HC_A),
        .GapCycles (GC_A),
        .NumOutputs(N_A)
    ) u_dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_a)
    );

    rst_release_seq #(
        .SyncStages(SS_B),
        .HoldCycles(HC_B),
        .GapCycles (8),
        .NumOutputs(1)
    ) u_dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge k = k-th rising edge that samples rst_n high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic wait_edge(input int k);
        int budget;
        budget = 300;
        while (edge_cnt < k && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (edge_cnt < k) check("wait_timeout", edge_cnt, k);
    endtask

    // Expected release schedule of instance A when the sequence restarts
    // from reference edge 'start' (SyncStages for rst_n, e for a request).
    task automatic plan_a(input int start);
        for (int i = 0; i < N_A; i++) begin
            q_a.push_back(exp_t'{start + HC_A + i * GC_A, 4'((1 << (i + 1)) - 1),
                                 (i == N_A - 1), (i != N_A - 1)});
        end
    endtask

    task automatic plan_b();
        q_b.push_back(exp_t'{SS_B + HC_B, 4'd1, 1'b1, 1'b0});
    endtask

    task automatic cancel_from(input int e);
        exp_t keep[$];
        foreach (q_a[i]) if (q_a[i].e < e) keep.push_back(q_a[i]);
        q_a = keep;
    endtask

    task automatic start_seq();
        plan_a(SS_A);
        plan_b();
        prev_a = 4'd0;
        prev_b = 4'd0;
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    // Called at a negedge: drops rst_n mid-cycle and checks the async clear
    // before the next rising edge.
    task automatic async_drop();
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_no", bus_a.rst_no, 4'd0);
        check("async_done", bus_a.seq_done_o, 1'b0);
        check("async_busy", bus_a.busy_o, 1'b1);
        check("async_b_rst_no", bus_b.rst_no, 1'b0);
        check("async_b_done", bus_b.seq_done_o, 1'b0);
        q_a.delete();
        q_b.delete();
        prev_a = 4'd0;
        prev_b = 4'd0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_a.rst_no !== prev_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_change", bus_a.rst_no, prev_a);
                end else begin
                    exp_t x;
                    x = q_a.pop_front();
                    check("a_edge", edge_cnt, x.e);
                    check("a_rst_no", bus_a.rst_no, x.val);
                    check("a_done", bus_a.seq_done_o, x.done);
                    check("a_busy", bus_a.busy_o, x.busy);
                end
                prev_a = bus_a.rst_no;
            end
            if ({3'd0, bus_b.rst_no} !== prev_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_change", {3'd0, bus_b.rst_no}, prev_b);
                end else begin
                    exp_t x;
                    x = q_b.pop_front();
                    check("b_edge", edge_cnt, x.e);
                    check("b_rst_no", {3'd0, bus_b.rst_no}, x.val);
                    check("b_done", bus_b.seq_done_o, x.done);
                    check("b_busy", bus_b.busy_o, x.busy);
                end
                prev_b = {3'd0, bus_b.rst_no};
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        prev_a   = 4'd0;
        prev_b   = 4'd0;
        rst_n    = 1'b0;
        bus_a.sw_rst_req_i = 1'b0;
        bus_b.sw_rst_req_i = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_rst_no", bus_a.rst_no, 4'd0);
        check("reset_done", bus_a.seq_done_o, 1'b0);
        check("reset_busy", bus_a.busy_o, 1'b1);
        check("reset_b_busy", bus_b.busy_o, 1'b1);

        // Sequence 1: request held over edges 1..2 is ignored (no rst_sync yet).
        start_seq();
        bus_a.sw_rst_req_i = 1'b1;
        wait_edge(2);
        bus_a.sw_rst_req_i = 1'b0;

        // One-cycle restart request sampled at edge 18.
        wait_edge(17);
        check("pre_req_rst_no", bus_a.rst_no, 4'b0011);
        bus_a.sw_rst_req_i = 1'b1;
        cancel_from(18);
        q_a.push_back(exp_t'{18, 4'd0, 1'b0, 1'b1});
        wait_edge(18);
        bus_a.sw_rst_req_i = 1'b0;
        plan_a(18);
        wait_edge(47);
        check("seq1_q_a_empty", q_a.size(), 0);
        check("seq1_q_b_empty", q_b.size(), 0);
        check("seq1_done", bus_a.seq_done_o, 1'b1);
        check("seq1_busy", bus_a.busy_o, 1'b0);

        // Full reset from a finished sequence.
        async_drop();
        repeat (3) @(negedge clk);
        start_seq();

        // Reset pulled between edges 10 and 11.
        wait_edge(10);
        check("pre_drop_rst_no", bus_a.rst_no, 4'b0001);
        async_drop();
        repeat (2) @(negedge clk);
        start_seq();

        // Request held over edges 40..44 after completion.
        wait_edge(39);
        check("seq3_q_a_empty", q_a.size(), 0);
        check("seq3_rst_no_all", bus_a.rst_no, 4'hF);
        check("seq3_done", bus_a.seq_done_o, 1'b1);
        bus_a.sw_rst_req_i = 1'b1;
        cancel_from(40);
        q_a.push_back(exp_t'{40, 4'd0, 1'b0, 1'b1});
        wait_edge(44);
        check("held_req_rst_no", bus_a.rst_no, 4'd0);
        check("held_req_busy", bus_a.busy_o, 1'b1);
        check("held_req_done", bus_a.seq_done_o, 1'b0);
        bus_a.sw_rst_req_i = 1'b0;
        plan_a(44);
        wait_edge(73);
        check("seq4_q_a_empty", q_a.size(), 0);
        check("seq4_q_b_empty", q_b.size(), 0);
        check("seq4_done", bus_a.seq_done_o, 1'b1);
        check("seq4_busy", bus_a.busy_o, 1'b0);
        check("seq4_b_done", bus_b.seq_done_o, 1'b1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
